// File: rtl/btn_pulse_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce FSM, and registered
// press / release / long-press event pulses plus the debounced level.
module btn_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES
                                                                          : LONG_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_HIGH = 2'd1,
        PRESSED  = 2'd2,
        ARM_LOW  = 2'd3
    } state_t;

    logic             s1;
    logic             btn_s;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             long_done_q;
    logic             long_done_d;

    logic             btn_level_d;
    logic             press_pulse_d;
    logic             release_pulse_d;
    logic             long_pulse_d;

    // Metastability guard: only btn_s is ever seen by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_in;
            btn_s <= s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            long_done_q   <= long_done_d;
            btn_level     <= btn_level_d;
            press_pulse   <= press_pulse_d;
            release_pulse <= release_pulse_d;
            long_pulse    <= long_pulse_d;
        end
    end

    // Next-state and next-output logic; pulses default low so each lasts one cycle.
    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        long_done_d     = long_done_q;
        btn_level_d     = btn_level;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = ARM_HIGH;
                    db_cnt_d = CNT_ONE;
                end
            end

            ARM_HIGH: begin
                if (!btn_s) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = PRESSED;
                    press_pulse_d = 1'b1;
                    btn_level_d   = 1'b1;
                    hold_cnt_d    = '0;
                    long_done_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            PRESSED: begin
                if (!btn_s) begin
                    state_d  = ARM_LOW;
                    db_cnt_d = CNT_ONE;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
                // long_done limits the long-press event to once per press
                if ((hold_cnt_q == HOLD_LAST) && !long_done_q) begin
                    long_pulse_d = 1'b1;
                    long_done_d  = 1'b1;
                end
            end

            ARM_LOW: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                    btn_level_d     = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench for btn_pulse_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Event cycle indices count edges after inputs are applied: edge 0 is cycle 1.
module tb_btn_pulse_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int tests = 0;
    int fails = 0;
    int cyc, press_n, rel_n, long_n, press_at, rel_at, long_at;
    int viol = 0;
    logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0;

    btn_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; press_n = 0; rel_n = 0; long_n = 0;
        press_at = -1; rel_at = -1; long_at = -1;
    endtask

    // One clock edge, then sample outputs 1 time unit later and log events.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (press_pulse === 1'b1)   begin press_n++; press_at = cyc; end
        if (release_pulse === 1'b1) begin rel_n++;   rel_at   = cyc; end
        if (long_pulse === 1'b1)    begin long_n++;  long_at  = cyc; end
        if (prev_p === 1'b1 && press_pulse === 1'b1)   viol++;
        if (prev_r === 1'b1 && release_pulse === 1'b1) viol++;
        if (prev_l === 1'b1 && long_pulse === 1'b1)    viol++;
        if (press_pulse === 1'b1 && release_pulse === 1'b1) viol++;
        prev_p = press_pulse;
        prev_r = release_pulse;
        prev_l = long_pulse;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset held with button high
        rst = 1'b1; btn_in = 1'b1;
        clr();
        ticks(3);
        chk("rst_level",   btn_level,     0);
        chk("rst_press",   press_pulse,   0);
        chk("rst_release", release_pulse, 0);
        chk("rst_long",    long_pulse,    0);
        rst = 1'b0;
        clr();
        ticks(5);
        chk("post_rst_no_early_press", press_n, 0);
        chk("post_rst_level_low", btn_level, 0);
        tick();
        chk("post_rst_press_now", press_pulse, 1);
        chk("post_rst_level_high", btn_level, 1);
        tick();
        chk("post_rst_press_dropped", press_pulse, 0);
        chk("post_rst_press_at", press_at, 6);

        // release to get back to idle
        btn_in = 1'b0;
        clr();
        ticks(10);
        chk("rel1_at", rel_at, 6);
        chk("rel1_count", rel_n, 1);
        chk("rel1_level", btn_level, 0);

        // 2: clean press held 12 cycles
        btn_in = 1'b1;
        clr();
        ticks(12);
        chk("p2_press_count", press_n, 1);
        chk("p2_press_at", press_at, 6);
        chk("p2_release_count", rel_n, 0);
        chk("p2_long_count", long_n, 0);
        chk("p2_level", btn_level, 1);
        btn_in = 1'b0;
        clr();
        ticks(10);
        chk("p2_rel_at", rel_at, 6);
        chk("p2_rel_level", btn_level, 0);

        // 3: bounce (1x3, 0x2) x4 then low: rejected
        clr();
        for (int k = 0; k < 4; k++) begin
            btn_in = 1'b1; ticks(3);
            btn_in = 1'b0; ticks(2);
        end
        ticks(10);
        chk("bounce_press_count", press_n, 0);
        chk("bounce_level", btn_level, 0);
        // a clean press afterwards has full nominal latency, so the FSM was idle
        btn_in = 1'b1;
        clr();
        ticks(8);
        chk("bounce_then_press_at", press_at, 6);

        // 4: short low glitch while pressed is absorbed
        btn_in = 1'b0; ticks(2);
        btn_in = 1'b1; ticks(10);
        chk("glitch_release_count", rel_n, 0);
        chk("glitch_press_count", press_n, 1);
        chk("glitch_level", btn_level, 1);
        btn_in = 1'b0;
        clr();
        ticks(10);
        chk("glitch_rel_count", rel_n, 1);

        // 5: long hold of 40 cycles
        btn_in = 1'b1;
        clr();
        ticks(40);
        chk("long_press_at", press_at, 6);
        chk("long_count", long_n, 1);
        chk("long_at", long_at, 26);
        btn_in = 1'b0;
        clr();
        ticks(10);
        chk("long_rel_at", rel_at, 6);
        chk("long_rel_level", btn_level, 0);
        chk("long_none_after_release", long_n, 0);

        // mid-operation reset while held: fresh press after reset
        btn_in = 1'b1;
        clr();
        ticks(8);
        chk("midrst_first_press", press_n, 1);
        rst = 1'b1;
        tick();
        chk("midrst_level", btn_level, 0);
        chk("midrst_press", press_pulse, 0);
        rst = 1'b0;
        clr();
        ticks(8);
        chk("midrst_repress_count", press_n, 1);
        chk("midrst_repress_at", press_at, 6);
        chk("midrst_repress_level", btn_level, 1);
        btn_in = 1'b0;
        ticks(10);

        // 6: 11 presses with contact bounce on both edges
        clr();
        for (int k = 0; k < 11; k++) begin
            btn_in = 1'b1; tick();
            btn_in = 1'b0; tick();
            btn_in = 1'b1; ticks(8);
            btn_in = 1'b0; tick();
            btn_in = 1'b1; tick();
            btn_in = 1'b0; ticks(8);
        end
        chk("chain_press_count", press_n, 11);
        chk("chain_release_count", rel_n, 11);
        chk("chain_long_count", long_n, 0);
        chk("chain_level", btn_level, 0);

        chk("pulse_width_exclusive", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
